// File: rtl/mem_responder16.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder16
//  Purpose  : Bus responder for the 16-bit pipeline. It provides a zero-wait
//             internal word RAM and a 256-word I/O window that uses a
//             req/ack handshake with a bounded timeout.
//  Revision : 1.0  initial release
// ============================================================================
module mem_responder16 #(
  parameter int          ADDR_BITS    = 12,
  parameter logic [15:0] IO_BASE      = 16'hFF00,
  parameter int          TIMEOUT      = 15,
  parameter logic [15:0] TIMEOUT_DATA = 16'hDEAD
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] ADDR,
  input  logic [15:0] DATA_IN,
  input  logic        mem_OEb,
  input  logic        mem_WRb,
  output logic [15:0] DATA_OUT,
  output logic        mem_WAITb,
  output logic        io_req,
  output logic        io_we,
  output logic [7:0]  io_addr,
  output logic [15:0] io_wdata,
  input  logic [15:0] io_rdata,
  input  logic        io_ack,
  output logic        ERR_UNMAPPED,
  output logic        ERR_TIMEOUT,
  input  logic        ERR_CLR
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IO_WAIT = 2'd1,
    S_IO_DONE = 2'd2
  } state_t;

  localparam int          c_RAM_WORDS = 1 << ADDR_BITS;
  localparam logic [16:0] c_RAM_END   = 17'(c_RAM_WORDS);
  localparam logic [16:0] c_IO_LAST   = {1'b0, IO_BASE} + 17'd255;
  localparam logic [7:0]  c_TO_LAST   = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_count;
  logic [15:0] r_rdata;
  logic [15:0] r_ram [c_RAM_WORDS];

  logic                 w_rd_act;
  logic                 w_wr_act;
  logic                 w_access;
  logic                 w_both;
  logic                 w_is_ram;
  logic                 w_is_io;
  logic                 w_idle;
  logic                 w_io_start;
  logic                 w_ram_we;
  logic                 w_set_unm;
  logic                 w_set_to;
  logic [ADDR_BITS-1:0] w_ram_idx;

  // A write strobe dominates: both strobes low is treated as a write.
  assign w_rd_act  = ~mem_OEb & mem_WRb;
  assign w_wr_act  = ~mem_WRb;
  assign w_access  = ~mem_OEb | ~mem_WRb;
  assign w_both    = ~mem_OEb & ~mem_WRb;
  assign w_is_ram  = ({1'b0, ADDR} < c_RAM_END);
  assign w_is_io   = (ADDR >= IO_BASE) && ({1'b0, ADDR} <= c_IO_LAST);
  assign w_ram_idx = ADDR[ADDR_BITS-1:0];

  assign w_idle     = (r_state == S_IDLE);
  assign w_io_start = w_idle & w_access & w_is_io;
  assign w_ram_we   = w_idle & w_wr_act & w_is_ram & ~RST;
  assign w_set_unm  = w_idle & w_access & (w_both | ~(w_is_ram | w_is_io));
  assign w_set_to   = (r_state == S_IO_WAIT) & ~io_ack & (r_count == c_TO_LAST);

  always_comb begin
    DATA_OUT = 16'h0000;
    case (r_state)
      S_IDLE:    if (w_rd_act && w_is_ram) DATA_OUT = r_ram[w_ram_idx];
      S_IO_DONE: if (!mem_OEb)             DATA_OUT = r_rdata;
      default:   DATA_OUT = 16'h0000;
    endcase
  end

  // Nothing is served while reset is held, so the stall request is released.
  assign mem_WAITb = RST | ~(w_io_start | (r_state == S_IO_WAIT));

  always_ff @(posedge CLK) begin
    if (w_ram_we) r_ram[w_ram_idx] <= DATA_IN;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_count  <= 8'd0;
      r_rdata  <= 16'h0000;
      io_req   <= 1'b0;
      io_we    <= 1'b0;
      io_addr  <= 8'h00;
      io_wdata <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_io_start) begin
            io_addr  <= ADDR[7:0] - IO_BASE[7:0];
            io_we    <= w_wr_act;
            io_wdata <= DATA_IN;
            io_req   <= 1'b1;
            r_count  <= 8'd0;
            r_state  <= S_IO_WAIT;
          end
        end
        S_IO_WAIT: begin
          // An ack coinciding with the final count still completes normally.
          if (io_ack) begin
            if (!io_we) r_rdata <= io_rdata;
            io_req  <= 1'b0;
            r_state <= S_IO_DONE;
          end else if (r_count == c_TO_LAST) begin
            r_rdata <= TIMEOUT_DATA;
            io_req  <= 1'b0;
            r_state <= S_IO_DONE;
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        S_IO_DONE: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ERR_UNMAPPED <= 1'b0;
      ERR_TIMEOUT  <= 1'b0;
    end else begin
      if (w_set_unm)    ERR_UNMAPPED <= 1'b1;
      else if (ERR_CLR) ERR_UNMAPPED <= 1'b0;
      if (w_set_to)     ERR_TIMEOUT  <= 1'b1;
      else if (ERR_CLR) ERR_TIMEOUT  <= 1'b0;
    end
  end

endmodule
`default_nettype wire
